tt_sweep_ctrl: RTL and testbench
================================

# tt_sweep_ctrl

Sequencer that exercises the 3-input combinational function block (inputs A, B, C; output F) through all eight input combinations in binary order and captures the result as an 8-bit truth table. It holds each combination for a programmable settle time, samples F, and compares the finished table against an expected mask. It sits between a host or bench controller (start/done handshake) and the function block, replacing hand-timed stimulus with a self-checking sweep.

## Interface

- SETTLE, default 4: cycles each combination is held before F is sampled; legal range 1..255, elaboration error otherwise.
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request a sweep; accepted only in IDLE.
- expected  in  8  golden truth table, bit i = F for {A,B,C}=i; latched on start acceptance.
- A  out  1  MSB of current combination.
- B  out  1  middle bit of current combination.
- C  out  1  LSB of current combination.
- F  in  1  function-block output.
- busy  out  1  high from the cycle after acceptance through the last SAMPLE cycle.
- done  out  1  one-cycle pulse when the table is complete.
- table  out  8  captured truth table.
- pass  out  1  table == latched expected; valid from done, held until next acceptance.
- mismatch_idx  out  3  lowest index where table and expected differ; 0 when pass.

## Operation

- States: IDLE, SETTLE, SAMPLE, DONE.
- IDLE: A/B/C = 0, busy = 0. On start=1 at a clock edge: latch expected, clear table, idx = 0, load settle counter with SETTLE-1, go to SETTLE.
- SETTLE: {A,B,C} = idx; counter decrements each cycle; at 0 go to SAMPLE.
- SAMPLE: {A,B,C} still = idx; table[idx] <= F. If idx = 7 go to DONE, else idx++, reload counter, go to SETTLE.
- DONE: done = 1, busy = 0, compute pass and mismatch_idx from the complete table; next state IDLE.
- start outside IDLE (including during DONE) is ignored; there is no queueing.
- table bits update live during a sweep; table, pass and mismatch_idx hold after DONE until the next acceptance.
- idx is 3 bits and never wraps during a sweep, because DONE exits at idx = 7.

## Timing

- Reset values: A=B=C=0, busy=0, done=0, table=8'h00, pass=0, mismatch_idx=0, state IDLE, idx=0.
- Each combination occupies SETTLE+1 cycles: SETTLE cycles held, then 1 sample cycle.
- Let the start acceptance edge be cycle 0. Combination i is driven during cycles i*(SETTLE+1)+1 through (i+1)*(SETTLE+1).
- done is high during cycle 8*(SETTLE+1)+1. With SETTLE=4, that is cycle 41.
- The earliest re-acceptance of start is the edge ending the first IDLE cycle after DONE.
- F is sampled registered at the end of the SAMPLE cycle; the function block has SETTLE+1 cycles of stable inputs.
- rst asserted mid-sweep forces all reset values immediately, without waiting for a clock edge. Any partial table is discarded and no done pulse is produced.

## Structure

- Package tt_sweep_pkg holds:
  - state enum (IDLE, SETTLE, SAMPLE, DONE);
  - N_COMB = 8 and IDX_W = 3;
  - the settle counter width, 8.
- Natural sub-module: settle_timer, a loadable down-counter with a zero flag, driven by load/enable from the FSM.
- The top level holds the FSM, idx register, table register and compare logic, including a priority encoder for mismatch_idx.

## Test plan

- F = A^B^C, expected 8'h96, SETTLE=4. Required: A/B/C step 000..111 every 5 cycles, done at cycle 41, table=8'h96, pass=1, mismatch_idx=0.
- F = A&B&C, expected 8'h81. Required: table=8'h80, pass=0, mismatch_idx=0.
- F = A|B, expected 8'hFC. Required: table=8'hFC, pass=1. Then immediately start with expected 8'h00; required: table cleared at acceptance, final pass=0, mismatch_idx=2.
- start pulsed at cycles 3, 20 and 41 of a running sweep. Required: exactly one done pulse, at cycle 41, and busy never drops before it.
- rst asserted at cycle 12 of a sweep. Required: all outputs return to reset values at once, no done pulse. A new start after reset completes normally.
- SETTLE=1 with F = ~A. Required: combinations change every 2 cycles, done at cycle 17, table=8'h0F.

Source files
------------

// File: rtl/tt_sweep_pkg.sv
// Shared types and sizing for the truth-table sweep controller.
// The state enum uses an ST_ prefix so it cannot clash with the SETTLE parameter.
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int N_COMB = 8;
  localparam int IDX_W  = 3;
  localparam int CNT_W  = 8;

  typedef logic [IDX_W-1:0]  idx_t;
  typedef logic [N_COMB-1:0] tt_t;
  typedef logic [CNT_W-1:0]  cnt_t;

  localparam idx_t IDX_LAST = idx_t'(N_COMB - 1);

endpackage

// File: rtl/tt_sweep_ctrl_if.sv
// Host-side start/done handshake and result bus of the sweep controller.
// The captured truth table is carried on tt_table because "table" is a reserved word.
interface tt_sweep_ctrl_if;
  import tt_sweep_pkg::*;

  logic start;
  tt_t  expected;
  logic busy;
  logic done;
  tt_t  tt_table;
  logic pass;
  idx_t mismatch_idx;

  modport master (
    output start,
    output expected,
    input  busy,
    input  done,
    input  tt_table,
    input  pass,
    input  mismatch_idx
  );

  modport slave (
    input  start,
    input  expected,
    output busy,
    output done,
    output tt_table,
    output pass,
    output mismatch_idx
  );

endinterface

// File: rtl/tt_sweep_ctrl_settle_timer.sv
// Loadable down-counter that times how long each combination is held.
// Stops at zero so the FSM can sit on the zero flag without wrap-around.
module tt_sweep_ctrl_settle_timer
  import tt_sweep_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  input  cnt_t load_val,
  output logic zero
);

  cnt_t cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/tt_sweep_ctrl.sv
// Steps a 3-input function block through all eight inputs, captures F into a
// truth table and grades it against a golden mask latched at start.
module tt_sweep_ctrl
  import tt_sweep_pkg::*;
#(
  parameter int SETTLE = 4
) (
  input  logic            clk,
  input  logic            rst,
  tt_sweep_ctrl_if.slave  sweep,
  output logic            A,
  output logic            B,
  output logic            C,
  input  logic            F
);

  if ((SETTLE < 1) || (SETTLE > 255)) begin : g_settle_range
    $error("tt_sweep_ctrl: SETTLE must be within 1..255");
  end

  localparam cnt_t RELOAD = cnt_t'(SETTLE - 1);

  state_t state;
  state_t state_nx;
  idx_t   idx;
  tt_t    expected_q;
  tt_t    table_q;
  tt_t    table_nx;
  tt_t    diff;
  logic   pass_q;
  idx_t   midx_q;
  idx_t   midx_nx;
  logic   tmr_load;
  logic   tmr_en;
  logic   tmr_zero;
  logic   accept;
  logic   active;

  tt_sweep_ctrl_settle_timer u_settle_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (RELOAD),
    .zero     (tmr_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (sweep.start) begin
          tmr_load = 1'b1;
          state_nx = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (tmr_zero) begin
          state_nx = ST_SAMPLE;
        end else begin
          tmr_en = 1'b1;
        end
      end
      ST_SAMPLE: begin
        if (idx == IDX_LAST) begin
          state_nx = ST_DONE;
        end else begin
          tmr_load = 1'b1;
          state_nx = ST_SETTLE;
        end
      end
      ST_DONE: begin
        state_nx = ST_IDLE;
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  assign accept = (state == ST_IDLE) && sweep.start;
  assign active = (state == ST_SETTLE) || (state == ST_SAMPLE);

  // Table as it will stand after this cycle's sample; grading the final
  // sample here lets pass/mismatch_idx be valid in the DONE cycle itself.
  always_comb begin
    table_nx      = table_q;
    table_nx[idx] = F;
    diff          = table_nx ^ expected_q;
    midx_nx       = '0;
    for (int i = N_COMB - 1; i >= 0; i--) begin
      if (diff[i]) begin
        midx_nx = idx_t'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx        <= '0;
      expected_q <= '0;
      table_q    <= '0;
      pass_q     <= 1'b0;
      midx_q     <= '0;
    end else if (accept) begin
      idx        <= '0;
      expected_q <= sweep.expected;
      table_q    <= '0;
      pass_q     <= 1'b0;
      midx_q     <= '0;
    end else if (state == ST_SAMPLE) begin
      table_q <= table_nx;
      if (idx == IDX_LAST) begin
        pass_q <= (diff == '0);
        midx_q <= midx_nx;
      end else begin
        idx <= idx + 1'b1;
      end
    end
  end

  assign {A, B, C}          = active ? idx : '0;
  assign sweep.busy         = active;
  assign sweep.done         = (state == ST_DONE);
  assign sweep.tt_table     = table_q;
  assign sweep.pass         = pass_q;
  assign sweep.mismatch_idx = midx_q;

endmodule

// File: tb/tb_tt_sweep_ctrl.sv
// Self-checking bench for tt_sweep_ctrl: SETTLE=4 and SETTLE=1 instances,
// expected sweep results queued at start and popped on the done pulse.
module tb_tt_sweep_ctrl;
  import tt_sweep_pkg::*;

  typedef struct packed {
    logic [7:0] tbl;
    logic       pass;
    logic [2:0] midx;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   f_sel;
  int   d_sel;
  int   checks   = 0;
  int   failures = 0;
  exp_t sb_q[$];

  logic a4, b4, c4, f4;
  logic a1, b1, c1, f1;

  tt_sweep_ctrl_if sw4 ();
  tt_sweep_ctrl_if sw1 ();

  function automatic logic fn(input int sel, input logic a, input logic b, input logic c);
    case (sel)
      0:       fn = a ^ b ^ c;
      1:       fn = a & b & c;
      2:       fn = a | b;
      default: fn = ~a;
    endcase
  endfunction

  assign f4 = fn(f_sel, a4, b4, c4);
  assign f1 = fn(f_sel, a1, b1, c1);

  tt_sweep_ctrl #(.SETTLE(4)) u_dut4 (
    .clk   (clk),
    .rst   (rst),
    .sweep (sw4.slave),
    .A     (a4),
    .B     (b4),
    .C     (c4),
    .F     (f4)
  );

  tt_sweep_ctrl #(.SETTLE(1)) u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .sweep (sw1.slave),
    .A     (a1),
    .B     (b1),
    .C     (c1),
    .F     (f1)
  );

  always #5 clk = ~clk;

  logic [2:0] o_abc;
  logic       o_busy, o_done, o_pass;
  logic [7:0] o_tbl;
  logic [2:0] o_midx;

  always_comb begin
    if (d_sel == 1) begin
      o_abc  = {a1, b1, c1};
      o_busy = sw1.busy;
      o_done = sw1.done;
      o_tbl  = sw1.tt_table;
      o_pass = sw1.pass;
      o_midx = sw1.mismatch_idx;
    end else begin
      o_abc  = {a4, b4, c4};
      o_busy = sw4.busy;
      o_done = sw4.done;
      o_tbl  = sw4.tt_table;
      o_pass = sw4.pass;
      o_midx = sw4.mismatch_idx;
    end
  end

  task automatic set_start(input int d, input logic v, input logic [7:0] mask);
    if (d == 1) begin
      sw1.start = v;
      if (v) sw1.expected = mask;
    end else begin
      sw4.start = v;
      if (v) sw4.expected = mask;
    end
  endtask

  // Caller is at a negedge; the following posedge accepts start (cycle 0).
  task automatic run_sweep(input string name, input int d, input int fs, input logic [7:0] mask,
                           input exp_t want, input int p0, input int p1, input int p2);
    int         s;
    int         done_cyc;
    logic [2:0] want_abc;
    exp_t       got;
    s        = (d == 1) ? 1 : 4;
    done_cyc = 8 * (s + 1) + 1;
    d_sel    = d;
    f_sel    = fs;
    set_start(d, 1'b1, mask);
    sb_q.push_back(want);
    @(posedge clk);
    for (int cyc = 1; cyc <= done_cyc + 1; cyc++) begin
      @(negedge clk);
      set_start(d, (cyc == p0) || (cyc == p1) || (cyc == p2), 8'h00);
      if (cyc != done_cyc) begin
        want_abc = (cyc < done_cyc) ? 3'((cyc - 1) / (s + 1)) : 3'd0;
        checks++;
        if (o_abc !== want_abc) begin
          failures++;
          $display("FAIL %s abc cyc=%0d got=%b want=%b", name, cyc, o_abc, want_abc);
        end
      end
      checks++;
      if (o_busy !== (cyc < done_cyc)) begin
        failures++;
        $display("FAIL %s busy cyc=%0d got=%b want=%b", name, cyc, o_busy, cyc < done_cyc);
      end
      checks++;
      if (o_done !== (cyc == done_cyc)) begin
        failures++;
        $display("FAIL %s done cyc=%0d got=%b want=%b", name, cyc, o_done, cyc == done_cyc);
      end
      if (cyc == 1) begin
        checks++;
        if ((o_tbl !== 8'h00) || (o_pass !== 1'b0)) begin
          failures++;
          $display("FAIL %s clear_at_accept table=%h pass=%b want table=00 pass=0", name, o_tbl, o_pass);
        end
      end
      if (o_done === 1'b1) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL %s unexpected_done cyc=%0d got done=1 want no pending sweep", name, cyc);
        end else begin
          got = sb_q.pop_front();
          if ((o_tbl !== got.tbl) || (o_pass !== got.pass) || (o_midx !== got.midx)) begin
            failures++;
            $display("FAIL %s result table=%h pass=%b midx=%0d want table=%h pass=%b midx=%0d",
                     name, o_tbl, o_pass, o_midx, got.tbl, got.pass, got.midx);
          end
        end
      end
      if (cyc == done_cyc + 1) begin
        checks++;
        if ((o_tbl !== want.tbl) || (o_pass !== want.pass) || (o_midx !== want.midx)) begin
          failures++;
          $display("FAIL %s hold table=%h pass=%b midx=%0d want table=%h pass=%b midx=%0d",
                   name, o_tbl, o_pass, o_midx, want.tbl, want.pass, want.midx);
        end
      end
    end
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL %s done_missing pending=%0d want 0", name, sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    rst          = 1'b1;
    sw4.start    = 1'b0;
    sw1.start    = 1'b0;
    sw4.expected = 8'h00;
    sw1.expected = 8'h00;
    f_sel        = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      d_sel = d;
      #1;
      checks++;
      if ({o_abc, o_busy, o_done, o_tbl, o_pass, o_midx} !== 17'd0) begin
        failures++;
        $display("FAIL reset_values dut=%0d abc=%b busy=%b done=%b table=%h pass=%b midx=%0d want all 0",
                 d, o_abc, o_busy, o_done, o_tbl, o_pass, o_midx);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_xor();
    run_sweep("xor", 0, 0, 8'h96, '{tbl: 8'h96, pass: 1'b1, midx: 3'd0}, -1, -1, -1);
  endtask

  task automatic test_and();
    run_sweep("and", 0, 1, 8'h81, '{tbl: 8'h80, pass: 1'b0, midx: 3'd0}, -1, -1, -1);
  endtask

  task automatic test_back_to_back();
    run_sweep("or_pass", 0, 2, 8'hFC, '{tbl: 8'hFC, pass: 1'b1, midx: 3'd0}, -1, -1, -1);
    run_sweep("or_b2b", 0, 2, 8'h00, '{tbl: 8'hFC, pass: 1'b0, midx: 3'd2}, -1, -1, -1);
  endtask

  task automatic test_start_ignored();
    run_sweep("start_ign", 0, 0, 8'h96, '{tbl: 8'h96, pass: 1'b1, midx: 3'd0}, 3, 20, 41);
  endtask

  task automatic test_reset_mid_sweep();
    d_sel = 0;
    f_sel = 0;
    set_start(0, 1'b1, 8'h96);
    @(posedge clk);
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clk);
      set_start(0, 1'b0, 8'h00);
    end
    checks++;
    if ((o_abc !== 3'd2) || (o_busy !== 1'b1) || (o_tbl !== 8'h02)) begin
      failures++;
      $display("FAIL rst_pre abc=%b busy=%b table=%h want abc=010 busy=1 table=02", o_abc, o_busy, o_tbl);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({o_abc, o_busy, o_done, o_tbl, o_pass, o_midx} !== 17'd0) begin
      failures++;
      $display("FAIL rst_async abc=%b busy=%b done=%b table=%h pass=%b midx=%0d want all 0",
               o_abc, o_busy, o_done, o_tbl, o_pass, o_midx);
    end
    repeat (3) begin
      @(negedge clk);
      checks++;
      if ((o_done !== 1'b0) || (o_busy !== 1'b0)) begin
        failures++;
        $display("FAIL rst_hold done=%b busy=%b want 0 0", o_done, o_busy);
      end
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ((o_done !== 1'b0) || (o_busy !== 1'b0) || (o_tbl !== 8'h00)) begin
      failures++;
      $display("FAIL rst_release done=%b busy=%b table=%h want 0 0 00", o_done, o_busy, o_tbl);
    end
    run_sweep("after_rst", 0, 0, 8'h96, '{tbl: 8'h96, pass: 1'b1, midx: 3'd0}, -1, -1, -1);
  endtask

  task automatic test_settle1();
    run_sweep("settle1", 1, 3, 8'h0F, '{tbl: 8'h0F, pass: 1'b1, midx: 3'd0}, -1, -1, -1);
  endtask

  initial begin
    d_sel = 0;
    test_reset();
    test_xor();
    test_and();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid_sweep();
    test_settle1();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
